// File: rtl/fake_entropy_source.sv
// Deterministic, simulation-only entropy source model: constant/counter/LFSR words
// at a programmable rate, buffered in a small FIFO behind a valid/ack handshake.
module fake_entropy_source #(
  parameter int          FIFO_DEPTH   = 4,
  parameter int unsigned DEFAULT_RATE = 16,
  parameter logic [31:0] SEED         = 32'h11223344,
  parameter logic [31:0] CONST_WORD   = 32'h11223344
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        noise,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        error,
  input  logic        discard,
  input  logic        test_mode,
  output logic        security_error,
  output logic        entropy_enabled,
  output logic [31:0] entropy_data,
  output logic        entropy_valid,
  input  logic        entropy_ack,
  output logic [7:0]  debug,
  input  logic        debug_update
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NAME_WORD = 32'h66616b65;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_STUCK = 2'd3
  } mode_t;

  typedef enum logic [7:0] {
    ADDR_NAME   = 8'h00,
    ADDR_CTRL   = 8'h08,
    ADDR_STATUS = 8'h09,
    ADDR_RATE   = 8'h0a,
    ADDR_SEED   = 8'h0b,
    ADDR_OVFCLR = 8'h0c
  } addr_t;

  logic        ctrl_enable;
  mode_t       ctrl_mode;
  logic        ctrl_fault;
  logic [15:0] rate;
  logic [31:0] state;
  logic [15:0] counter;
  logic        overflow;
  logic [31:0] last_pop;
  logic [7:0]  debug_q;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] fill;
  logic [7:0]  fill_ext;
  logic        empty;
  logic        full;

  logic        rd_ok;
  logic        wr_ok;
  logic [31:0] rd_val;
  logic        access_ok;
  logic        wr_en;
  logic        ctrl_wr;
  logic        rate_wr;
  logic        seed_wr;
  logic        ovfclr_wr;

  logic        run;
  logic        flush;
  logic        gen;
  logic        push;
  logic        pop;
  logic        ovf_set;
  logic [15:0] rate_nz;
  logic [15:0] r_m1;
  logic [31:0] gen_word;
  logic [31:0] lfsr_next;
  logic [31:0] state_next;

  assign fill     = wr_ptr - rd_ptr;
  assign fill_ext = 8'(fill);
  assign empty    = (fill == '0);
  assign full     = (fill == (AW + 1)'(FIFO_DEPTH));

  // Register decode
  always_comb begin
    rd_ok  = 1'b0;
    wr_ok  = 1'b0;
    rd_val = '0;
    case (address)
      ADDR_NAME: begin
        rd_ok  = 1'b1;
        rd_val = NAME_WORD;
      end
      ADDR_CTRL: begin
        rd_ok  = 1'b1;
        wr_ok  = 1'b1;
        rd_val = {28'd0, ctrl_fault, ctrl_mode, ctrl_enable};
      end
      ADDR_STATUS: begin
        rd_ok  = 1'b1;
        rd_val = {16'd0, fill_ext, 6'd0, overflow, ~empty};
      end
      ADDR_RATE: begin
        rd_ok  = 1'b1;
        wr_ok  = 1'b1;
        rd_val = {16'd0, rate};
      end
      ADDR_SEED, ADDR_OVFCLR: wr_ok = 1'b1;
      default: ;
    endcase
    access_ok = we ? wr_ok : rd_ok;
  end

  assign error     = cs & ~access_ok;
  assign read_data = (!we && rd_ok) ? rd_val : '0;
  assign wr_en     = cs & we & wr_ok;
  assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
  assign rate_wr   = wr_en && (address == ADDR_RATE);
  assign seed_wr   = wr_en && (address == ADDR_SEED);
  assign ovfclr_wr = wr_en && (address == ADDR_OVFCLR);

  // Generator timing and FIFO control
  assign rate_nz  = (rate == '0) ? 16'd1 : rate;
  assign r_m1     = test_mode ? 16'd0 : rate_nz - 16'd1;
  assign run      = ctrl_enable && (ctrl_mode != MODE_STUCK);
  assign flush    = discard | (ctrl_wr & ctrl_enable & ~write_data[0]);
  // >= rather than == so lowering RATE below the running count cannot stall the generator
  assign gen      = run & (counter >= r_m1) & ~flush;
  assign pop      = entropy_ack & ~empty & ~flush;
  assign push     = gen & (~full | pop);
  assign ovf_set  = gen & full & ~pop;

  assign gen_word  = (ctrl_mode == MODE_CONST) ? CONST_WORD : state;
  assign lfsr_next = (state >> 1) ^ (state[0] ? LFSR_TAPS : 32'd0);

  always_comb begin
    state_next = state;
    if (seed_wr) begin
      state_next = write_data;
    end else if (gen) begin
      case (ctrl_mode)
        MODE_COUNT: state_next = state + 32'd1;
        MODE_LFSR:  state_next = lfsr_next;
        default:    state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_enable <= 1'b1;
      ctrl_mode   <= MODE_CONST;
      ctrl_fault  <= 1'b0;
      rate        <= 16'(DEFAULT_RATE);
      state       <= SEED;
      counter     <= '0;
      overflow    <= 1'b0;
      last_pop    <= '0;
      debug_q     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_enable <= write_data[0];
        ctrl_mode   <= mode_t'(write_data[2:1]);
        ctrl_fault  <= write_data[3];
      end
      if (rate_wr)
        rate <= write_data[15:0];
      state <= state_next;

      if (flush)
        counter <= '0;
      else if (run)
        counter <= gen ? 16'd0 : counter + 16'd1;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr   <= rd_ptr + 1'b1;
          last_pop <= mem[rd_ptr[AW-1:0]];
        end
      end

      if (ovf_set)
        overflow <= 1'b1;
      else if (ovfclr_wr)
        overflow <= 1'b0;

      if (debug_update)
        debug_q <= last_pop[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[wr_ptr[AW-1:0]] <= gen_word;
  end

  assign entropy_valid   = ~empty;
  assign entropy_data    = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];
  assign security_error  = ctrl_fault;
  assign entropy_enabled = ctrl_enable;
  assign debug           = debug_q;

endmodule

// File: tb/tb_fake_entropy_source.sv
// Directed bench for fake_entropy_source: rate timing, modes, FIFO full/overflow,
// discard, register errors and mid-operation reset.
module tb_fake_entropy_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        noise = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        error;
  logic        discard = 1'b0;
  logic        test_mode = 1'b0;
  logic        security_error;
  logic        entropy_enabled;
  logic [31:0] entropy_data;
  logic        entropy_valid;
  logic        entropy_ack = 1'b0;
  logic [7:0]  debug;
  logic        debug_update = 1'b0;

  int checks = 0;
  int failures = 0;

  fake_entropy_source #(
    .FIFO_DEPTH  (4),
    .DEFAULT_RATE(16),
    .SEED        (32'h11223344),
    .CONST_WORD  (32'h11223344)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .noise          (noise),
    .cs             (cs),
    .we             (we),
    .address        (address),
    .write_data     (write_data),
    .read_data      (read_data),
    .error          (error),
    .discard        (discard),
    .test_mode      (test_mode),
    .security_error (security_error),
    .entropy_enabled(entropy_enabled),
    .entropy_data   (entropy_data),
    .entropy_valid  (entropy_valid),
    .entropy_ack    (entropy_ack),
    .debug          (debug),
    .debug_update   (debug_update)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    tick();
    cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [31:0] d, output logic e);
    cs = 1'b1; we = 1'b0; address = a;
    #1;
    d = read_data;
    e = error;
    cs = 1'b0; address = '0;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (entropy_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (entropy_valid !== 1'b0 || entropy_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_fifo: valid=%b data=%h want valid=0 data=0", entropy_valid, entropy_data);
    end
    checks++;
    if (security_error !== 1'b0 || entropy_enabled !== 1'b1 || debug !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: sec=%b en=%b dbg=%h want 0 1 00", security_error, entropy_enabled, debug);
    end
    read_reg(8'h00, d, e);
    checks++;
    if (d !== 32'h66616b65 || e !== 1'b0) begin
      failures++;
      $display("FAIL reset_name: got %h err=%b want 66616b65 err=0", d, e);
    end
    read_reg(8'h08, d, e);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL reset_ctrl: got %h want 00000001", d);
    end
    read_reg(8'h0a, d, e);
    checks++;
    if (d !== 32'd16) begin
      failures++;
      $display("FAIL reset_rate: got %h want 00000010", d);
    end
    read_reg(8'h09, d, e);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_status: got %h want 00000000", d);
    end
  endtask

  // Starts in cycle 0 right after reset release
  task automatic test_const_rate();
    bit early = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (entropy_valid !== 1'b0) early = 1'b1;
      tick();
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL const_first_valid: valid seen before cycle 16, want first at 16");
    end
    checks++;
    if (entropy_valid !== 1'b1 || entropy_data !== 32'h11223344) begin
      failures++;
      $display("FAIL const_word: valid=%b data=%h want 1 11223344", entropy_valid, entropy_data);
    end
    checks++;
    if (debug !== 8'h00) begin
      failures++;
      $display("FAIL debug_before_update: got %h want 00", debug);
    end
    entropy_ack = 1'b1;
    tick();
    entropy_ack = 1'b0;
    checks++;
    if (entropy_valid !== 1'b0) begin
      failures++;
      $display("FAIL const_pop: valid=%b want 0", entropy_valid);
    end
    debug_update = 1'b1;
    tick();
    debug_update = 1'b0;
    checks++;
    if (debug !== 8'h44) begin
      failures++;
      $display("FAIL debug_latch: got %h want 44", debug);
    end
  endtask

  task automatic test_counter_mode();
    bit ok;
    write_reg(8'h08, 32'h0);
    write_reg(8'h0b, 32'h11223344);
    test_mode = 1'b1;
    entropy_ack = 1'b1;
    write_reg(8'h08, 32'h3);
    wait_valid(8, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL counter_wait: valid=0 after 8 cycles want 1");
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (entropy_valid !== 1'b1 || entropy_data !== 32'h11223344 + 32'(k)) begin
        failures++;
        $display("FAIL counter_word%0d: valid=%b data=%h want 1 %h", k, entropy_valid,
                 entropy_data, 32'h11223344 + 32'(k));
      end
      tick();
    end
    entropy_ack = 1'b0;
    test_mode = 1'b0;
    write_reg(8'h08, 32'h0);
  endtask

  task automatic test_lfsr_mode();
    bit ok;
    logic [31:0] exp;
    write_reg(8'h0b, 32'h1);
    test_mode = 1'b1;
    entropy_ack = 1'b1;
    write_reg(8'h08, 32'h5);
    wait_valid(8, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL lfsr_wait: valid=0 after 8 cycles want 1");
    end
    exp = 32'h1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (entropy_valid !== 1'b1 || entropy_data !== exp) begin
        failures++;
        $display("FAIL lfsr_word%0d: valid=%b data=%h want 1 %h", k, entropy_valid, entropy_data, exp);
      end
      exp = lfsr_step(exp);
      tick();
    end
    entropy_ack = 1'b0;
    test_mode = 1'b0;
    write_reg(8'h08, 32'h0);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic e;
    write_reg(8'h0a, 32'h1);
    write_reg(8'h0b, 32'h11223344);
    write_reg(8'h08, 32'h3);
    repeat (8) tick();
    read_reg(8'h09, d, e);
    checks++;
    if (d !== 32'h0403 || e !== 1'b0) begin
      failures++;
      $display("FAIL ovf_status_full: got %h err=%b want 00000403 err=0", d, e);
    end
    checks++;
    if (entropy_data !== 32'h11223344) begin
      failures++;
      $display("FAIL ovf_head: got %h want 11223344", entropy_data);
    end
    write_reg(8'h08, 32'h7);
    write_reg(8'h0c, 32'h0);
    read_reg(8'h09, d, e);
    checks++;
    if (d !== 32'h0401) begin
      failures++;
      $display("FAIL ovfclr: got %h want 00000401", d);
    end
    write_reg(8'h08, 32'h3);
    entropy_ack = 1'b1;
    tick();
    checks++;
    if (entropy_data !== 32'h11223345) begin
      failures++;
      $display("FAIL full_push_pop_head: got %h want 11223345", entropy_data);
    end
    read_reg(8'h09, d, e);
    checks++;
    if (d !== 32'h0401) begin
      failures++;
      $display("FAIL full_push_pop_status: got %h want 00000401", d);
    end
    tick();
    write_reg(8'h08, 32'h7);
    entropy_ack = 1'b0;
    read_reg(8'h09, d, e);
    checks++;
    if (d !== 32'h0401) begin
      failures++;
      $display("FAIL full_push_pop_no_ovf: got %h want 00000401", d);
    end
  endtask

  task automatic test_discard();
    logic [31:0] d;
    logic e;
    bit early = 1'b0;
    entropy_ack = 1'b1;
    tick();
    entropy_ack = 1'b0;
    read_reg(8'h09, d, e);
    checks++;
    if (d !== 32'h0301) begin
      failures++;
      $display("FAIL discard_setup: got %h want 00000301", d);
    end
    write_reg(8'h0a, 32'h4);
    write_reg(8'h08, 32'h3);
    discard = 1'b1;
    tick();
    discard = 1'b0;
    read_reg(8'h09, d, e);
    checks++;
    if (entropy_valid !== 1'b0 || d !== 32'h0) begin
      failures++;
      $display("FAIL discard_flush: valid=%b status=%h want 0 00000000", entropy_valid, d);
    end
    for (int c = 0; c < 4; c++) begin
      if (entropy_valid !== 1'b0) early = 1'b1;
      tick();
    end
    checks++;
    if (early || entropy_valid !== 1'b1) begin
      failures++;
      $display("FAIL discard_restart: early=%b valid=%b want early=0 valid=1 at cycle 4", early, entropy_valid);
    end
    write_reg(8'h08, 32'h0);
  endtask

  task automatic test_fault_error();
    logic [31:0] d;
    logic e;
    write_reg(8'h08, 32'h9);
    checks++;
    if (security_error !== 1'b1 || entropy_enabled !== 1'b1) begin
      failures++;
      $display("FAIL fault_flag: sec=%b en=%b want 1 1", security_error, entropy_enabled);
    end
    read_reg(8'h0b, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL read_wo: err=%b data=%h want 1 00000000", e, d);
    end
    read_reg(8'h05, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      failures++;
      $display("FAIL read_unmapped: err=%b data=%h want 1 00000000", e, d);
    end
    cs = 1'b1; we = 1'b1; address = 8'h09; write_data = 32'hffffffff;
    #1;
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL write_ro: err=%b want 1", error);
    end
    tick();
    cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
    read_reg(8'h08, d, e);
    checks++;
    if (e !== 1'b0 || d !== 32'h9) begin
      failures++;
      $display("FAIL ctrl_readback: err=%b data=%h want 0 00000009", e, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic e;
    repeat (10) tick();
    checks++;
    if (entropy_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_precondition: valid=%b want 1", entropy_valid);
    end
    entropy_ack = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    entropy_ack = 1'b0;
    checks++;
    if (entropy_valid !== 1'b0 || security_error !== 1'b0 || entropy_enabled !== 1'b1 || debug !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_outputs: valid=%b sec=%b en=%b dbg=%h want 0 0 1 00",
               entropy_valid, security_error, entropy_enabled, debug);
    end
    read_reg(8'h08, d, e);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL mid_reset_ctrl: got %h want 00000001", d);
    end
    read_reg(8'h0a, d, e);
    checks++;
    if (d !== 32'd16) begin
      failures++;
      $display("FAIL mid_reset_rate: got %h want 00000010", d);
    end
  endtask

  initial begin
    test_reset();
    test_const_rate();
    test_counter_mode();
    test_lfsr_mode();
    test_overflow();
    test_discard();
    test_fault_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
